data_read_capture: RTL and testbench

//  Capture engine downstream of the AXI-lite write slave. A one-cycle cr_start pulse

---
 rtl/data_read_capture_pkg.sv | 18 +
 rtl/data_read_capture_buf.sv | 30 +++
 rtl/data_read_capture.sv | 157 +++++++++++++++
 tb/tb_data_read_capture.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_read_capture_pkg.sv
// Shared definitions for the capture engine: FSM states, status-register bit
// positions and the read-side buffer window base.
package data_read_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } cap_state_t;

  localparam int SR_BUSY_BIT    = 0;
  localparam int SR_DONE_BIT    = 1;
  localparam int SR_OVF_BIT     = 2;
  localparam int SR_TIMEOUT_BIT = 3;

  localparam logic [31:0] BUF_BASE_ADDR = 32'h0000_0100;

endpackage

// File: rtl/data_read_capture_buf.sv
// data_read_buf: simple dual-port RAM, synchronous write, registered read.
// A same-address read and write in one cycle returns the old word.
module data_read_buf #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_rdata <= '0;
    else          r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_read_capture.sv
// Capture engine: cr_start arms capture of cr_len samples from din/din_valid into
// data_read_buf. Optional idle timeout is enabled by defining DATA_READ_TIMEOUT_EN.
module data_read_capture
  import data_read_capture_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 8,
  parameter int TIMEOUT_W = 16
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESETN,
  input  logic              cr_start,
  input  logic [ADDR_W:0]   cr_len,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              sr_busy,
  output logic              sr_done,
  output logic              sr_ovf,
  output logic              sr_timeout,
  output logic [ADDR_W:0]   sr_count
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  cap_state_t        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_wr_ptr, w_wr_ptr_nxt;
  logic [ADDR_W:0]   r_count, w_count_nxt;
  logic [ADDR_W:0]   r_len, w_len_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_ovf, w_ovf_nxt;
  logic              w_we;
  logic [ADDR_W:0]   w_len_in;

  // Zero means a full buffer; oversize requests are clamped so no write wraps past len.
  assign w_len_in = (cr_len == '0 || cr_len > DEPTH) ? DEPTH : cr_len;

`ifdef DATA_READ_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] r_idle, w_idle_nxt;
  logic                 r_timeout, w_timeout_nxt;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_wr_ptr_nxt = r_wr_ptr;
    w_count_nxt  = r_count;
    w_len_nxt    = r_len;
    w_busy_nxt   = r_busy;
    w_done_nxt   = r_done;
    w_ovf_nxt    = r_ovf;
    w_we         = 1'b0;
`ifdef DATA_READ_TIMEOUT_EN
    w_idle_nxt    = r_idle;
    w_timeout_nxt = r_timeout;
`endif
    case (r_state)
      ST_CAPTURE: begin
        if (din_valid) begin
          w_we         = 1'b1;
          w_wr_ptr_nxt = r_wr_ptr + 1'b1;
          w_count_nxt  = r_count + 1'b1;
`ifdef DATA_READ_TIMEOUT_EN
          w_idle_nxt   = '0;
`endif
          if (r_count == r_len - 1'b1) begin
            w_state_nxt = ST_DONE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end
        end
`ifdef DATA_READ_TIMEOUT_EN
        else begin
          w_idle_nxt = r_idle + 1'b1;
          if (&w_idle_nxt) begin
            w_state_nxt   = ST_DONE;
            w_busy_nxt    = 1'b0;
            w_done_nxt    = 1'b1;
            w_timeout_nxt = 1'b1;
          end
        end
`endif
      end
      default: begin
        // IDLE and DONE: a start wins over a coincident sample, which is dropped.
        if (cr_start) begin
          w_state_nxt  = ST_CAPTURE;
          w_wr_ptr_nxt = '0;
          w_count_nxt  = '0;
          w_len_nxt    = w_len_in;
          w_busy_nxt   = 1'b1;
          w_done_nxt   = 1'b0;
          w_ovf_nxt    = 1'b0;
`ifdef DATA_READ_TIMEOUT_EN
          w_idle_nxt    = '0;
          w_timeout_nxt = 1'b0;
`endif
        end else if (r_state == ST_DONE && din_valid) begin
          w_ovf_nxt = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state  <= ST_IDLE;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_len    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
`ifdef DATA_READ_TIMEOUT_EN
      r_idle    <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_wr_ptr <= w_wr_ptr_nxt;
      r_count  <= w_count_nxt;
      r_len    <= w_len_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_ovf    <= w_ovf_nxt;
`ifdef DATA_READ_TIMEOUT_EN
      r_idle    <= w_idle_nxt;
      r_timeout <= w_timeout_nxt;
`endif
    end
  end

  data_read_buf #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_buf (
    .i_clk   (S_AXI_ACLK),
    .i_rst_n (S_AXI_ARESETN),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (din),
    .i_raddr (rd_addr),
    .o_rdata (rd_data)
  );

  assign sr_busy  = r_busy;
  assign sr_done  = r_done;
  assign sr_ovf   = r_ovf;
  assign sr_count = r_count;
`ifdef DATA_READ_TIMEOUT_EN
  assign sr_timeout = r_timeout;
`else
  assign sr_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_data_read_capture.sv
// Self-checking bench for data_read_capture: directed scenarios plus randomized
// captures against a transaction-level model. Timeout scenario follows DATA_READ_TIMEOUT_EN.
module tb_data_read_capture;

`ifdef DATA_READ_TIMEOUT_EN
  localparam int TW = 4;
`else
  localparam int TW = 16;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cr_start = 1'b0;
  logic [8:0]  cr_len = '0;
  logic [15:0] din = '0;
  logic        din_valid = 1'b0;
  logic [7:0]  rd_addr = '0;
  logic [15:0] rd_data;
  logic        sr_busy, sr_done, sr_ovf, sr_timeout;
  logic [8:0]  sr_count;

  int n_total = 0;
  int n_bad   = 0;

  // Model: capture in progress flag, target length, samples taken, sticky flags.
  bit          m_cap, m_done, m_ovf, m_to;
  int          m_len, m_cnt, m_idle;
  logic [15:0] m_mem [256];
  bit          m_written [256];

  data_read_capture #(.DATA_W(16), .ADDR_W(8), .TIMEOUT_W(TW)) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .cr_start      (cr_start),
    .cr_len        (cr_len),
    .din           (din),
    .din_valid     (din_valid),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .sr_busy       (sr_busy),
    .sr_done       (sr_done),
    .sr_ovf        (sr_ovf),
    .sr_timeout    (sr_timeout),
    .sr_count      (sr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cap = 0; m_done = 0; m_ovf = 0; m_to = 0; m_cnt = 0; m_len = 0; m_idle = 0;
  endtask

  task automatic model_step(input bit st, input int len, input bit vld, input logic [15:0] d);
    if (!m_cap) begin
      if (st) begin
        m_cap = 1; m_done = 0; m_ovf = 0; m_to = 0; m_cnt = 0; m_idle = 0;
        m_len = (len == 0 || len > 256) ? 256 : len;
      end else if (m_done && vld) begin
        m_ovf = 1;
      end
    end else if (vld) begin
      m_mem[m_cnt % 256] = d;
      m_written[m_cnt % 256] = 1;
      m_cnt++;
      m_idle = 0;
      if (m_cnt == m_len) begin
        m_cap = 0; m_done = 1;
      end
    end else begin
`ifdef DATA_READ_TIMEOUT_EN
      m_idle++;
      if (m_idle == (1 << TW) - 1) begin
        m_cap = 0; m_done = 1; m_to = 1;
      end
`endif
    end
  endtask

  task automatic check_status();
    chk("busy", sr_busy, m_cap);
    chk("done", sr_done, m_done);
    chk("ovf", sr_ovf, m_ovf);
    chk("timeout", sr_timeout, m_to);
    chk("count", sr_count, m_cnt);
  endtask

  // One clock: apply inputs, advance the model at the edge, check 1 time unit later.
  task automatic cyc(input bit st, input bit vld, input logic [15:0] d);
    bit          rd_known;
    logic [15:0] rd_exp;
    cr_start = st; din_valid = vld; din = d;
    rd_known = m_written[rd_addr];
    rd_exp   = m_mem[rd_addr];
    @(posedge clk);
    if (rst_n) model_step(st, int'(cr_len), vld, d);
    #1;
    cr_start = 0; din_valid = 0;
    check_status();
    if (!rst_n) chk("rd_rst", rd_data, 16'h0);
    else if (rd_known) chk("rd_data", rd_data, rd_exp);
  endtask

  task automatic read_back(input int n);
    for (int a = 0; a <= n; a++) begin
      rd_addr = 8'(a % 256);
      cyc(0, 0, 16'h0);
    end
  endtask

  initial begin
    int budget;
    for (int i = 0; i < 256; i++) begin m_written[i] = 0; m_mem[i] = '0; end
    model_reset();

    // Reset state
    repeat (3) cyc(0, 0, 16'h0);
    rst_n = 1'b1;
    cyc(0, 1, 16'hbeef);

    // 1. Basic capture of 4 samples
    cr_len = 9'd4;
    cyc(1, 0, 16'h0);
    for (int i = 1; i <= 4; i++) cyc(0, 1, 16'(i * 16'h1111));
    chk("basic_done", sr_done, 1'b1);
    chk("basic_count", sr_count, 9'd4);
    read_back(4);

    // 2. Full-depth capture with random gaps
    cr_len = 9'd0;
    cyc(1, 0, 16'h0);
    budget = 0;
    while (m_cap && budget < 2000) begin
      rd_addr = 8'($urandom_range(0, 255));
      cyc(0, ($urandom_range(0, 3) != 0), 16'($urandom));
      budget++;
    end
    chk("full_budget", (budget < 2000), 1'b1);
    chk("full_count", sr_count, 9'd256);
    chk("full_busy", sr_busy, 1'b0);
    read_back(256);

    // 3. Start with coincident sample, then overflow after DONE
    cr_len = 9'd3;
    cyc(1, 1, 16'hdead);
    chk("drop_count", sr_count, 9'd0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 16'(16'h0a00 + i));
    chk("edge_done", sr_done, 1'b1);
    chk("edge_ovf0", sr_ovf, 1'b0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 16'hffff);
    chk("edge_ovf1", sr_ovf, 1'b1);
    rd_addr = 8'd0;
    cyc(0, 0, 16'h0);
    chk("drop_word", rd_data, 16'h0a00);
    cr_len = 9'd1;
    cyc(1, 0, 16'h0);
    chk("restart_ovf", sr_ovf, 1'b0);
    chk("restart_done", sr_done, 1'b0);
    cyc(0, 1, 16'h5a5a);

    // 4. Start pulse mid-capture is ignored
    cr_len = 9'd8;
    cyc(1, 0, 16'h0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 16'(16'h4000 + i));
    cr_len = 9'd2;
    cyc(1, 0, 16'h0);
    chk("mid_count", sr_count, 9'd3);
    for (int i = 3; i < 8; i++) cyc(0, 1, 16'(16'h4000 + i));
    chk("mid_final", sr_count, 9'd8);
    chk("mid_done", sr_done, 1'b1);
    read_back(8);

    // 5. Asynchronous reset mid-capture
    cr_len = 9'd8;
    cyc(1, 0, 16'h0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 16'(16'h7000 + i));
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_busy", sr_busy, 1'b0);
    chk("arst_count", sr_count, 9'd0);
    chk("arst_flags", {sr_done, sr_ovf, sr_timeout}, 3'b000);
    cyc(0, 1, 16'h0);
    rst_n = 1'b1;
    cr_len = 9'd2;
    cyc(1, 0, 16'h0);
    cyc(0, 1, 16'h1234);
    cyc(0, 1, 16'h5678);
    chk("post_rst_done", sr_done, 1'b1);
    read_back(2);

    // 6. Idle timeout behaviour
    cr_len = 9'd8;
    cyc(1, 0, 16'h0);
    cyc(0, 1, 16'h0101);
    cyc(0, 1, 16'h0202);
`ifdef DATA_READ_TIMEOUT_EN
    repeat (15) cyc(0, 0, 16'h0);
    chk("to_flag", sr_timeout, 1'b1);
    chk("to_done", sr_done, 1'b1);
    chk("to_count", sr_count, 9'd2);
`else
    repeat (100) cyc(0, 0, 16'h0);
    chk("noto_busy", sr_busy, 1'b1);
    for (int i = 0; i < 6; i++) cyc(0, 1, 16'(16'h0300 + i));
    chk("noto_done", sr_done, 1'b1);
`endif

    // Randomized captures with stray start pulses and post-DONE traffic
    for (int r = 0; r < 8; r++) begin
      cr_len = 9'($urandom_range(0, 24));
      cyc(1, ($urandom_range(0, 1) == 1), 16'($urandom));
      budget = 0;
      while (m_cap && budget < 400) begin
        rd_addr = 8'($urandom_range(0, 31));
        cyc(($urandom_range(0, 15) == 0), ($urandom_range(0, 9) < 7), 16'($urandom));
        budget++;
      end
      chk("rand_budget", (budget < 400), 1'b1);
      repeat (4) begin
        rd_addr = 8'($urandom_range(0, 31));
        cyc(0, ($urandom_range(0, 1) == 1), 16'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
